// File: rtl/adder6_sync.sv
// 6-bit unsigned ripple-carry adder built from gate cells, with a registered 7-bit result.
// Optional ADDER6_INPUT_REG_EN adds an operand register stage in front of the core (latency 2).

module xor2_cell (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

module nand2_cell (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

// a&b | ci&(a^b) as NAND(NAND(a,b), NAND(p,ci)) keeps the carry path two gates deep.
module fa_gate (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p, g_n, t_n;

  xor2_cell  u_p   (.a(a),   .b(b),   .y(p));
  xor2_cell  u_s   (.a(p),   .b(ci),  .y(s));
  nand2_cell u_g   (.a(a),   .b(b),   .y(g_n));
  nand2_cell u_t   (.a(p),   .b(ci),  .y(t_n));
  nand2_cell u_co  (.a(g_n), .b(t_n), .y(co));
endmodule

module adder6_sync (
  input  logic clk,
  input  logic rst,
  input  logic x0,
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  input  logic x5,
  input  logic y0,
  input  logic y1,
  input  logic y2,
  input  logic y3,
  input  logic y4,
  input  logic y5,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic s4,
  output logic s5,
  output logic s6
);
  logic [5:0] x_in, y_in;
  logic [5:0] x_core, y_core;
  logic [5:0] sum;
  logic [6:0] carry;
  logic [6:0] s_d, s_q;

  assign x_in = {x5, x4, x3, x2, x1, x0};
  assign y_in = {y5, y4, y3, y2, y1, y0};

`ifdef ADDER6_INPUT_REG_EN
  logic [5:0] x_d, x_q, y_d, y_q;

  always_comb begin
    x_d = x_in;
    y_d = y_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_core = x_q;
  assign y_core = y_q;
`else
  assign x_core = x_in;
  assign y_core = y_in;
`endif

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < 6; i++) begin : g_fa
    fa_gate u_fa (
      .a  (x_core[i]),
      .b  (y_core[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  always_comb begin
    s_d = {carry[6], sum};
  end

  always_ff @(posedge clk) begin
    if (rst) s_q <= '0;
    else     s_q <= s_d;
  end

  assign {s6, s5, s4, s3, s2, s1, s0} = s_q;
endmodule

// File: tb/tb_adder6_sync.sv
// Directed + exhaustive bench for adder6_sync; a cycle model built on plain X+Y checks every cycle.

module tb_adder6_sync;
`ifdef ADDER6_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] xv = '0, yv = '0;
  logic [6:0] s;
  logic s0, s1, s2, s3, s4, s5, s6;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adder6_sync dut (
    .clk(clk), .rst(rst),
    .x0(xv[0]), .x1(xv[1]), .x2(xv[2]), .x3(xv[3]), .x4(xv[4]), .x5(xv[5]),
    .y0(yv[0]), .y1(yv[1]), .y2(yv[2]), .y3(yv[3]), .y4(yv[4]), .y5(yv[5]),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5), .s6(s6)
  );

  assign s = {s6, s5, s4, s3, s2, s1, s0};

  // Model: each edge yields 0 under reset, else the arithmetic sum; delayed LAT edges,
  // where reset also clears any value still in flight.
  int unsigned pipe [0:LAT-1];
  logic model_ok = 1'b0;
  always @(posedge clk) begin
    int unsigned nxt;
    nxt = rst ? 0 : int'(xv) + int'(yv);
    for (int k = LAT - 1; k > 0; k--) pipe[k] = rst ? 0 : pipe[k-1];
    pipe[0] = nxt;
    if (rst) model_ok = 1'b1;
  end

  // Inputs change at negedge+1, so the negedge sees stable post-edge outputs.
  always @(negedge clk) begin
    if (model_ok) begin
      checks++;
      if (s !== 7'(pipe[LAT-1])) begin
        errors++;
        $display("FAIL model_cmp t=%0t s=%0d expected=%0d", $time, s, pipe[LAT-1]);
      end
    end
  end

  task automatic drive(input logic [5:0] x, input logic [5:0] y, input logic r);
    @(negedge clk);
    #1;
    xv = x; yv = y; rst = r;
  endtask

  task automatic lit(input string name, input logic [6:0] exp);
    checks++;
    if (s !== exp) begin
      errors++;
      $display("FAIL %s s=%0d expected=%0d", name, s, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic vec(input string name, input logic [5:0] x, input logic [5:0] y,
                     input logic [6:0] exp);
    drive(x, y, 1'b0);
    wait_edges(LAT);
    lit(name, exp);
  endtask

  initial begin
    // Reset held two cycles with max operands: output must stay 0.
    xv = 6'd63; yv = 6'd63; rst = 1'b1;
    wait_edges(1);
    lit("reset_c1", 7'd0);
    wait_edges(1);
    lit("reset_c2", 7'd0);

    vec("zero",      6'd0,  6'd0,  7'd0);
    vec("identity",  6'd42, 6'd0,  7'd42);
    vec("max_carry", 6'd63, 6'd63, 7'b1111110);
    vec("ripple",    6'd63, 6'd1,  7'b1000000);
    vec("no_carry",  6'd42, 6'd21, 7'd63);
    vec("one_one",   6'd1,  6'd1,  7'd2);
    vec("mid_carry", 6'd31, 6'd33, 7'd64);

    // Reset pulsed for one edge mid-stream with X=5,Y=9.
    vec("pre_rst",   6'd5,  6'd9,  7'd14);
    drive(6'd5, 6'd9, 1'b1);
    wait_edges(1);
    lit("mid_rst", 7'd0);
    drive(6'd5, 6'd9, 1'b0);
    wait_edges(LAT);
    lit("post_rst", 7'd14);

    // Exhaustive streaming sweep, one new pair every cycle.
    for (int x = 0; x < 64; x++)
      for (int y = 0; y < 64; y++)
        drive(6'(x), 6'(y), 1'b0);
    wait_edges(LAT);
    lit("last_pair", 7'd126);

    @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
